// File: rtl/bounce_pkg.sv
// bounce_pkg: shared constants and helpers for the bounce hit display.
//   - LED ring width and number of display digits
//   - active-low seven-segment codes {g,f,e,d,c,b,a} and anode select codes
//   - seg_decode: BCD nibble to segment pattern (non-decimal nibbles blank)
//   - bcd_inc:    increment of a packed 4-digit BCD value, 9999 wraps to 0000
package bounce_pkg;

  localparam int LED_W   = 16;
  localparam int NDIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anode select per digit index; index 0 is the rightmost (ones) digit.
  localparam logic [3:0] DIGIT_SEL [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Ripple the carry up through the digits; a carry out of the top digit is
  // dropped, which gives the 9999 -> 0000 wrap.
  function automatic logic [4*NDIGITS-1:0] bcd_inc(input logic [4*NDIGITS-1:0] v);
    logic [4*NDIGITS-1:0] r;
    logic                 carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bounce_hit_display_seg7_scan.sv
// seg7_scan: multiplexed 4-digit seven-segment driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   count      : four packed BCD digits, count[3:0] = ones
//   DIGIT      : active-low anode select (registered)
//   DISPLAY    : active-low segments {g,f,e,d,c,b,a} (registered)
// A free-running SCAN_W-bit prescaler produces a scan edge every 2^SCAN_W
// cycles. On each scan edge the anode and segment outputs are loaded for
// digit_idx_reg, which then advances, so the first scan edge after reset shows
// digit 0 and the outputs stay dark until then.
module seg7_scan
  import bounce_pkg::*;
#(
  parameter int SCAN_W   = 17,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   count,
  output logic [3:0]             DIGIT,
  output logic [6:0]             DISPLAY
);

  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [1:0]         digit_idx_reg;
  logic [3:0]         digit_reg;
  logic [6:0]         display_reg;
  logic               scan_tick;

  logic [3:0]         nib [NDIGITS];
  logic [NDIGITS-1:0] upper_zero;   // bit k: digit k and every digit above it are zero
  logic               zero_run;
  logic               blank;
  logic [6:0]         display_next;

  assign scan_tick = &scan_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_nib
      assign nib[gi] = count[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run && (nib[k] == 4'd0);
      upper_zero[k] = zero_run;
    end
  end

  // Digit 0 is never blanked so a zero count still shows a single '0'.
  always_comb begin
    blank        = BLANK_LZ && (digit_idx_reg != 2'd0) && upper_zero[digit_idx_reg];
    display_next = blank ? SEG_BLANK : seg_decode(nib[digit_idx_reg]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= 2'd0;
      digit_reg     <= 4'b1111;
      display_reg   <= SEG_BLANK;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
      if (scan_tick) begin
        digit_reg     <= DIGIT_SEL[digit_idx_reg];
        display_reg   <= display_next;
        digit_idx_reg <= digit_idx_reg + 2'd1;
      end
    end
  end

  assign DIGIT   = digit_reg;
  assign DISPLAY = display_reg;

endmodule

// File: rtl/bounce_hit_display.sv
// bounce_hit_display: counts "hit" events of the two-dot bouncing LED ring and
// shows the count on the multiplexed 4-digit seven-segment display.
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : strobe, led holds a freshly updated pattern this cycle
//   run        : hit detection enabled only while high
//   clear      : one-cycle pulse, zeroes the count (highest priority)
//   led        : LED ring pattern, bit 15 and bit 0 are neighbours
//   hit        : one-cycle registered pulse per counted hit
//   count      : four packed BCD digits, count[3:0] = ones
//   DIGIT      : active-low anode select
//   DISPLAY    : active-low segments {g,f,e,d,c,b,a}
module bounce_hit_display
  import bounce_pkg::*;
#(
  parameter int SCAN_W   = 17,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step,
  input  logic                 run,
  input  logic                 clear,
  input  logic [LED_W-1:0]     led,
  output logic                 hit,
  output logic [4*NDIGITS-1:0] count,
  output logic [3:0]           DIGIT,
  output logic [6:0]           DISPLAY
);

  logic                 adj;
  logic                 adjacent_pair;
  logic                 single_dot;
  logic                 prev_adj_reg;
  logic                 hit_reg;
  logic [4*NDIGITS-1:0] count_reg;

  // Dots touch when two ring neighbours are lit (rotation wraps bit 15 to 0),
  // or when both dots sit on the same LED and only one bit is lit.
  assign adjacent_pair = |(led & {led[LED_W-2:0], led[LED_W-1]});
  assign single_dot    = (led != '0) && ((led & (led - 1'b1)) == '0);
  assign adj           = adjacent_pair || single_dot;

  // prev_adj_reg makes a sustained touch count once; it re-arms only after a
  // running step sees the dots apart. Steps with run=0 leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      hit_reg      <= 1'b0;
      prev_adj_reg <= 1'b0;
    end else if (clear) begin
      count_reg    <= '0;
      hit_reg      <= 1'b0;
      prev_adj_reg <= 1'b0;
    end else begin
      hit_reg <= 1'b0;
      if (step && run) begin
        prev_adj_reg <= adj;
        if (adj && !prev_adj_reg) begin
          count_reg <= bcd_inc(count_reg);
          hit_reg   <= 1'b1;
        end
      end
    end
  end

  assign hit   = hit_reg;
  assign count = count_reg;

  seg7_scan #(
    .SCAN_W   (SCAN_W),
    .BLANK_LZ (BLANK_LZ)
  ) u_seg7_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .count   (count_reg),
    .DIGIT   (DIGIT),
    .DISPLAY (DISPLAY)
  );

endmodule

// File: tb/tb_bounce_hit_display.sv
// Testbench for bounce_hit_display (SCAN_W=3). Two instances share stimulus:
// dut blanks leading zeros, dut_nb shows all digits.
module tb_bounce_hit_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] led = 16'h0000;
  logic        hit, hit_nb;
  logic [15:0] count, count_nb;
  logic [3:0]  digit_a, digit_b;
  logic [6:0]  display_a, display_b;

  always #5 clk = ~clk;

  bounce_hit_display #(.SCAN_W(3), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .run(run), .clear(clear), .led(led),
    .hit(hit), .count(count), .DIGIT(digit_a), .DISPLAY(display_a)
  );

  bounce_hit_display #(.SCAN_W(3), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .step(step), .run(run), .clear(clear), .led(led),
    .hit(hit_nb), .count(count_nb), .DIGIT(digit_b), .DISPLAY(display_b)
  );

  typedef struct {
    string       tag;
    logic        hit;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic        model_prev = 1'b0;
  logic [15:0] model_count = 16'h0000;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_2     = 7'b0100100;
  localparam logic [6:0] S_4     = 7'b0011001;
  logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] disp42_lz [4] = '{S_2, S_4, S_BLANK, S_BLANK};
  logic [6:0] disp42_nb [4] = '{S_2, S_4, S_0, S_0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_adj(input logic [15:0] v);
    int ones = 0;
    bit touch = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) ones++;
      if (v[i] && v[(i + 1) % 16]) touch = 1'b1;
    end
    return touch || (ones == 1);
  endfunction

  function automatic logic [15:0] model_next(input logic [15:0] v);
    int n;
    logic [3:0] d0, d1, d2, d3;
    n  = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    n  = (n + 1) % 10000;
    d3 = 4'(n / 1000);
    d2 = 4'((n / 100) % 10);
    d1 = 4'((n / 10) % 10);
    d0 = 4'(n % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One step strobe: expectation is pushed as the stimulus is driven and
  // popped once the DUT has taken the edge that ends the step cycle.
  task automatic do_step(input string tag, input logic [15:0] l, input logic r,
                         input logic c, input int gap, input bit verbose);
    exp_t e;
    bit   a;
    led   = l;
    run   = r;
    clear = c;
    step  = 1'b1;
    e.tag = tag;
    e.hit = 1'b0;
    if (c) begin
      model_count = 16'h0000;
      model_prev  = 1'b0;
    end else if (r) begin
      a = model_adj(l);
      if (a && !model_prev) begin
        model_count = model_next(model_count);
        e.hit       = 1'b1;
      end
      model_prev = a;
    end
    e.count = model_count;
    sb.push_back(e);
    tick();
    step  = 1'b0;
    clear = 1'b0;
    e = sb.pop_front();
    check({e.tag, " hit"}, 32'(hit), 32'(e.hit));
    check({e.tag, " count"}, 32'(count), 32'(e.count));
    if (verbose)
      $display("step %s led=%h run=%b clear=%b -> hit=%b count=%h", tag, l, r, c, hit, count);
    if (gap > 0) begin
      tick();
      check({e.tag, " hit_low"}, 32'(hit), 32'd0);
      for (int i = 1; i < gap; i++) tick();
    end
  endtask

  task automatic pump_to(input logic [15:0] target);
    while (model_count != target)
      do_step("pump", model_prev ? 16'h0000 : 16'h0003, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic check_first_scan(input string tag);
    for (int i = 0; i < 7; i++) tick();
    check({tag, " dark_digit"}, 32'(digit_a), 32'(4'b1111));
    check({tag, " dark_disp"}, 32'(display_a), 32'(S_BLANK));
    tick();
    check({tag, " first_digit"}, 32'(digit_a), 32'(4'b1110));
    check({tag, " first_disp"}, 32'(display_a), 32'(S_0));
    check({tag, " first_disp_nb"}, 32'(display_b), 32'(S_0));
    $display("scan %s DIGIT=%b DISPLAY=%b", tag, digit_a, display_a);
  endtask

  task automatic wait_digit(input logic [3:0] target, input int limit, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (digit_a == target) ok = 1'b1;
    end
    check({tag, " sync"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    run = 1'b1;
    led = 16'h0402;
    tick();
    tick();
    check("rst count", 32'(count), 32'h0);
    check("rst hit", 32'(hit), 32'h0);
    check("rst digit", 32'(digit_a), 32'(4'b1111));
    check("rst disp", 32'(display_a), 32'(S_BLANK));
    $display("reset count=%h hit=%b DIGIT=%b DISPLAY=%b", count, hit, digit_a, display_a);
    rst_n = 1'b1;
    check_first_scan("scan0");

    // Dots apart, then meeting
    do_step("apart0", 16'h0402, 1'b1, 1'b0, 7, 1'b1);
    do_step("apart1", 16'h0801, 1'b1, 1'b0, 7, 1'b1);
    do_step("apart2", 16'h0201, 1'b1, 1'b0, 7, 1'b1);
    do_step("meet",   16'h0003, 1'b1, 1'b0, 7, 1'b1);
    check("meet abs", 32'(count), 32'h0001);

    // Sustained adjacency counts once
    do_step("sep", 16'h0005, 1'b1, 1'b0, 2, 1'b1);
    for (int i = 0; i < 5; i++) do_step("hold", 16'h0003, 1'b1, 1'b0, 0, 1'b1);
    do_step("sep2", 16'h0005, 1'b1, 1'b0, 1, 1'b1);
    do_step("rearm", 16'h0003, 1'b1, 1'b0, 1, 1'b1);
    check("rearm abs", 32'(count), 32'h0003);

    // Ring wrap, merged dots, empty ring
    do_step("gap", 16'h0000, 1'b1, 1'b0, 1, 1'b1);
    do_step("wrap8001", 16'h8001, 1'b1, 1'b0, 1, 1'b1);
    do_step("gap", 16'h0000, 1'b1, 1'b0, 1, 1'b1);
    do_step("merged", 16'h0100, 1'b1, 1'b0, 1, 1'b1);
    do_step("empty", 16'h0000, 1'b1, 1'b0, 1, 1'b1);
    do_step("empty2", 16'h0000, 1'b1, 1'b0, 1, 1'b1);
    check("wrap abs", 32'(count), 32'h0005);

    // run=0 steps are ignored entirely
    do_step("norun", 16'h0003, 1'b0, 1'b0, 1, 1'b1);
    do_step("run_hit", 16'h0003, 1'b1, 1'b0, 1, 1'b1);
    do_step("norun0", 16'h0000, 1'b0, 1'b0, 1, 1'b1);
    do_step("run_held", 16'h0003, 1'b1, 1'b0, 1, 1'b1);
    check("run abs", 32'(count), 32'h0006);

    // clear beats a coincident rising step
    do_step("gap", 16'h0000, 1'b1, 1'b0, 1, 1'b1);
    do_step("clr_step", 16'h0003, 1'b1, 1'b1, 1, 1'b1);
    check("clr abs", 32'(count), 32'h0000);
    do_step("after_clr", 16'h0003, 1'b1, 1'b0, 1, 1'b1);
    check("after_clr abs", 32'(count), 32'h0001);

    // Display of 0042
    pump_to(16'h0042);
    do_step("park", 16'h0000, 1'b1, 1'b0, 1, 1'b1);
    wait_digit(4'b0111, 40, "d42a");
    wait_digit(4'b1110, 16, "d42b");
    check("d42 disp0", 32'(display_a), 32'(disp42_lz[0]));
    check("d42 disp0_nb", 32'(display_b), 32'(disp42_nb[0]));
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < 7; i++) tick();
      check("d42 hold", 32'(digit_a), 32'(sel_tab[(k - 1) % 4]));
      tick();
      check("d42 digit", 32'(digit_a), 32'(sel_tab[k % 4]));
      check("d42 digit_nb", 32'(digit_b), 32'(sel_tab[k % 4]));
      check("d42 disp", 32'(display_a), 32'(disp42_lz[k % 4]));
      check("d42 disp_nb", 32'(display_b), 32'(disp42_nb[k % 4]));
      $display("scan d42 DIGIT=%b DISPLAY=%b DISPLAY_nb=%b", digit_a, display_a, display_b);
    end

    // BCD carries and wrap
    pump_to(16'h0999);
    do_step("gap", 16'h0000, 1'b1, 1'b0, 0, 1'b1);
    do_step("carry999", 16'h0003, 1'b1, 1'b0, 0, 1'b1);
    check("carry abs", 32'(count), 32'h1000);
    pump_to(16'h9999);
    do_step("gap", 16'h0000, 1'b1, 1'b0, 0, 1'b1);
    do_step("wrap9999", 16'h0003, 1'b1, 1'b0, 0, 1'b1);
    check("wrap9999 abs", 32'(count), 32'h0000);
    check("wrap9999 hit", 32'(hit), 32'd1);
    tick();

    // Asynchronous reset in the middle of scanning and counting
    do_step("gap", 16'h0000, 1'b1, 1'b0, 0, 1'b1);
    do_step("pre_rst", 16'h0003, 1'b1, 1'b0, 3, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst count", 32'(count), 32'h0);
    check("arst hit", 32'(hit), 32'h0);
    check("arst digit", 32'(digit_a), 32'(4'b1111));
    check("arst disp", 32'(display_a), 32'(S_BLANK));
    $display("async reset count=%h DIGIT=%b", count, digit_a);
    model_count = 16'h0000;
    model_prev  = 1'b0;
    tick();
    rst_n = 1'b1;
    check_first_scan("scan_rst");
    do_step("post_rst", 16'h0003, 1'b1, 1'b0, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
